// File: rtl/wishbone_ram_slave_if.sv
// Wishbone classic-pipelined bus bundle for wishbone_ram_slave.
// Signal names match the slave's port names so waveforms read like the datasheet.
interface wishbone_ram_slave_if;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [29:0] i_wb_addr;
    logic [31:0] i_wb_data;
    logic        o_wb_ack;
    logic        o_wb_stall;
    logic        o_wb_err;
    logic [31:0] o_wb_data;

    modport master (
        output i_wb_cyc,
        output i_wb_stb,
        output i_wb_we,
        output i_wb_addr,
        output i_wb_data,
        input  o_wb_ack,
        input  o_wb_stall,
        input  o_wb_err,
        input  o_wb_data
    );

    modport slave (
        input  i_wb_cyc,
        input  i_wb_stb,
        input  i_wb_we,
        input  i_wb_addr,
        input  i_wb_data,
        output o_wb_ack,
        output o_wb_stall,
        output o_wb_err,
        output o_wb_data
    );
endinterface

// File: rtl/wishbone_ram_slave.sv
// Wishbone pipelined 32-bit RAM slave with 0..15 programmable wait states.
// Define WB_SLAVE_ADDR_ERR_EN to answer out-of-range addresses with err instead of aliasing.
module wishbone_ram_slave #(
    parameter int unsigned MEMORY_DEPTH = 1024,
    parameter int unsigned WAIT_STATES  = 0
) (
    input logic                 i_clk,
    input logic                 i_reset,
    wishbone_ram_slave_if.slave bus
);
    localparam int unsigned AddrW = $clog2(MEMORY_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [31:0]      mem [MEMORY_DEPTH];
    logic [31:0]      rdata_q;
    logic [AddrW-1:0] idx;
    logic             accept;
    logic             addr_err;
    logic             wr_en;
    logic             rd_en;
    logic             resp;

    assign idx = bus.i_wb_addr[AddrW-1:0];

    // Reset is folded in so a request presented during reset cannot touch the array.
    assign accept = bus.i_wb_cyc & bus.i_wb_stb & ~bus.o_wb_stall & ~i_reset;
    assign wr_en  = accept & bus.i_wb_we & ~addr_err;
    assign rd_en  = accept & ~bus.i_wb_we & ~addr_err;

    assign bus.o_wb_stall = (state_q == StWait);
    assign bus.o_wb_data  = rdata_q;

    // A completion is only signalled while the master still owns the cycle.
    assign resp = (state_q == StResp) & bus.i_wb_cyc;

`ifdef WB_SLAVE_ADDR_ERR_EN
    logic err_q;

    assign addr_err = ({2'b00, bus.i_wb_addr} >= MEMORY_DEPTH);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= addr_err;
        end
    end

    assign bus.o_wb_ack = resp & ~err_q;
    assign bus.o_wb_err = resp & err_q;
`else
    logic unused_addr_hi;

    assign addr_err       = 1'b0;
    assign unused_addr_hi = ^bus.i_wb_addr[29:AddrW];
    assign bus.o_wb_ack   = resp;
    assign bus.o_wb_err   = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[idx] <= bus.i_wb_data;
        end
    end

    // Non-blocking read of mem returns the pre-write value for same-edge traffic.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rdata_q <= 32'h0;
        end else if (rd_en) begin
            rdata_q <= mem[idx];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle, StResp: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (!bus.i_wb_cyc) begin
                    // Master abandoned the cycle; any write already landed.
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = StResp;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    ack_err_exclusive: assert property (@(posedge i_clk) disable iff (i_reset)
        !(bus.o_wb_ack && bus.o_wb_err));

    cnt_in_range: assert property (@(posedge i_clk) disable iff (i_reset)
        cnt_q <= 4'(WAIT_STATES));
endmodule

// File: tb/tb_wishbone_ram_slave.sv
// Bench for wishbone_ram_slave: three instances (0, 2 and 3 wait states) driven with directed
// and random traffic, responses scored against a behavioural memory model.
module tb_wishbone_ram_slave;
    localparam int unsigned Depth = 1024;
`ifdef WB_SLAVE_ADDR_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    typedef struct packed {
        logic        is_err;
        logic [31:0] data;
        logic        chk;
        int          cyc;
    } exp_t;

    function automatic int ws(input int d);
        return (d == 0) ? 0 : d + 1;
    endfunction

    logic clk = 1'b0;
    logic rst;
    int   cyc_n = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    logic [2:0]  cyc_s, stb_s, we_s;
    logic [29:0] addr_s [3];
    logic [31:0] wdat_s [3];
    logic [2:0]  ack_v, err_v, stall_v;
    logic [31:0] rdat_v [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        wishbone_ram_slave_if bus ();
        assign bus.i_wb_cyc  = cyc_s[g];
        assign bus.i_wb_stb  = stb_s[g];
        assign bus.i_wb_we   = we_s[g];
        assign bus.i_wb_addr = addr_s[g];
        assign bus.i_wb_data = wdat_s[g];
        assign ack_v[g]      = bus.o_wb_ack;
        assign err_v[g]      = bus.o_wb_err;
        assign stall_v[g]    = bus.o_wb_stall;
        assign rdat_v[g]     = bus.o_wb_data;

        wishbone_ram_slave #(
            .MEMORY_DEPTH(Depth),
            .WAIT_STATES ((g == 0) ? 0 : g + 1)
        ) u_dut (
            .i_clk  (clk),
            .i_reset(rst),
            .bus    (bus.slave)
        );
    end

    exp_t        exp_q [3][$];
    logic [31:0] mmem [3][Depth];
    bit          mwr [3][Depth];
    logic [31:0] last_rd [3];
    bit          last_kn [3];
    int          st_lo [3];
    int          st_hi [3];
    int          n_chk = 0;
    int          n_err = 0;

    task automatic check(input string name, input int d, input logic [31:0] got,
                         input logic [31:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, d, cyc_n, got, expv);
        end
    endtask

    // Monitor: stall window, ack/err exclusivity and ordered response scoring.
    exp_t e;
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            check("stall", d, 32'(stall_v[d]), 32'(cyc_n >= st_lo[d] && cyc_n <= st_hi[d]));
            check("ack_err_excl", d, 32'(ack_v[d] & err_v[d]), 32'(0));
            if (ack_v[d] || err_v[d]) begin
                if (exp_q[d].size() == 0) begin
                    check("spurious_resp", d, 32'({ack_v[d], err_v[d]}), 32'(0));
                end else begin
                    e = exp_q[d].pop_front();
                    check("resp_cycle", d, 32'(cyc_n), 32'(e.cyc));
                    check("resp_is_err", d, 32'(err_v[d]), 32'(e.is_err));
                    if (e.chk) check("rdata", d, rdat_v[d], e.data);
                end
            end else if (exp_q[d].size() != 0 && exp_q[d][0].cyc < cyc_n) begin
                check("resp_cycle", d, 32'(cyc_n), 32'(exp_q[d][0].cyc));
                void'(exp_q[d].pop_front());
            end
        end
    end

    // Present one request, wait (bounded) for acceptance, update the model, queue the response.
    task automatic req(input int d, input bit we, input logic [29:0] a, input logic [31:0] wd,
                       output int k);
        int   idx;
        bit   is_err;
        bit   ok;
        exp_t ex;
        cyc_s[d] = 1'b1;
        stb_s[d] = 1'b1;
        we_s[d] = we;
        addr_s[d] = a;
        wdat_s[d] = wd;
        ok = 1'b0;
        k = -1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (!stall_v[d]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("accept_timeout", d, 32'(stall_v[d]), 32'(0));
            stb_s[d] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        k = cyc_n;
        idx = int'(a % 30'(Depth));
        is_err = ErrEn && (a >= 30'(Depth));
        if (!is_err) begin
            if (we) begin
                mmem[d][idx] = wd;
                mwr[d][idx] = 1'b1;
            end else begin
                last_rd[d] = mmem[d][idx];
                last_kn[d] = mwr[d][idx];
            end
        end
        ex.is_err = is_err;
        ex.data = last_rd[d];
        ex.chk = last_kn[d];
        ex.cyc = k + ws(d);
        exp_q[d].push_back(ex);
        st_lo[d] = k;
        st_hi[d] = k + ws(d) - 1;
        stb_s[d] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input int d);
        for (int t = 0; t < 60 && exp_q[d].size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        if (exp_q[d].size() != 0) begin
            check("drain_timeout", d, 32'(exp_q[d].size()), 32'(0));
            exp_q[d].delete();
        end
        cyc_s[d] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        int          k0;
        logic [29:0] a;
        rst = 1'b0;
        cyc_s = '0;
        stb_s = '0;
        we_s = '0;
        for (int d = 0; d < 3; d++) begin
            addr_s[d] = '0;
            wdat_s[d] = '0;
            last_rd[d] = '0;
            last_kn[d] = 1'b1;
            st_lo[d] = 1;
            st_hi[d] = 0;
        end
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check("reset_ack", d, 32'(ack_v[d]), 32'(0));
            check("reset_err", d, 32'(err_v[d]), 32'(0));
            check("reset_data", d, rdat_v[d], 32'(0));
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Zero wait states: write then read back.
        req(0, 1'b1, 30'd5, 32'hAABB_CCDD, k);
        req(0, 1'b0, 30'd5, 32'h0, k);
        drain(0);

        // Zero wait states: pipelined writes and reads.
        for (int i = 1; i <= 3; i++) req(0, 1'b1, 30'(i), 32'(i * 32'h11), k);
        for (int i = 1; i <= 3; i++) req(0, 1'b0, 30'(i), 32'h0, k);
        drain(0);

        // Three wait states.
        req(2, 1'b1, 30'd5, 32'h5555_0005, k);
        req(2, 1'b0, 30'd5, 32'h0, k);
        drain(2);

        // Two wait states: master drops cyc during the wait.
        req(1, 1'b1, 30'd7, 32'h0000_005A, k);
        cyc_s[1] = 1'b0;
        void'(exp_q[1].pop_back());
        st_hi[1] = k;
        idle(3);
        k0 = cyc_n;
        req(1, 1'b0, 30'd7, 32'h0, k);
        check("accept_after_abort", 1, 32'(k), 32'(k0 + 1));
        drain(1);

        // Out-of-range address: err (no write) or alias onto word 5.
        req(0, 1'b1, 30'd5, 32'hCAFE_0005, k);
        req(0, 1'b1, 30'd1029, 32'h1234_5678, k);
        req(0, 1'b0, 30'd5, 32'h0, k);
        drain(0);

        // Reset in the middle of a wait.
        req(2, 1'b0, 30'd5, 32'h0, k);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            check("midreset_ack", d, 32'(ack_v[d]), 32'(0));
            check("midreset_err", d, 32'(err_v[d]), 32'(0));
            check("midreset_stall", d, 32'(stall_v[d]), 32'(0));
            check("midreset_data", d, rdat_v[d], 32'(0));
            exp_q[d].delete();
            st_lo[d] = 1;
            st_hi[d] = 0;
            last_rd[d] = '0;
            last_kn[d] = 1'b1;
            cyc_s[d] = 1'b0;
            stb_s[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // First edge after reset accepts; memory survived reset.
        k0 = cyc_n;
        req(0, 1'b0, 30'd5, 32'h0, k);
        check("first_accept", 0, 32'(k), 32'(k0 + 1));
        drain(0);
        req(2, 1'b0, 30'd5, 32'h0, k);
        drain(2);
        idle(6);

        // Random traffic on every instance.
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 50; i++) begin
                a = ($urandom_range(0, 3) == 0) ? 30'($urandom) : 30'($urandom_range(0, 15));
                req(d, 1'($urandom_range(0, 1)), a, $urandom, k);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
            drain(d);
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
